rs_alu: RTL and testbench
=========================

# rs_alu

Reservation station for the ALU. Buffers up to `RS_SIZE` dispatched integer operations, tracks unresolved operands by RoB tag, and wakes them from the two common data buses (ALU and LSB). Each cycle it issues at most one ready entry to the ALU as registered `vj/vk/imm/op/waiting`. It returns the issued entry's RoB tag aligned with the ALU's `finish/ALU_value`, so that the pair forms the ALU CDB broadcast.

## Interface
Parameters:
- `RS_SIZE`, 8 — number of entries; must be a power of 2, at least 2.
- `ROB_W`, 4 — RoB tag width.

Ports:
- `clk_in` input 1 — system clock.
- `rst_in` input 1 — reset, asynchronous, active-low.
- `rdy_in` input 1 — global ready; low freezes all state.
- `RoB_clear` input 1 — misprediction flush, synchronous.
- `disp_valid` input 1 — dispatch request this cycle.
- `disp_op` input 6 — ALU op encoding, passed through unchanged.
- `disp_vj`, `disp_vk` input 32 each — operand values.
- `disp_qj_busy`, `disp_qk_busy` input 1 each — high means the operand is still pending.
- `disp_qj`, `disp_qk` input ROB_W each — producer tags for pending operands.
- `disp_imm` input 32 — immediate.
- `disp_rob_id` input ROB_W — destination tag.
- `rs_full` output 1 — no free entry (combinational from current state).
- `alu_vj`, `alu_vk`, `alu_imm` output 32 each — registered, to the ALU.
- `alu_op` output 6 — registered, to the ALU.
- `alu_waiting` output 1 — registered; high for exactly the cycle an issued op is presented.
- `alu_finish` input 1, `alu_value` input 32 — ALU result.
- `alu_rob_id` output ROB_W — tag of the result currently on `alu_finish/alu_value`.
- `lsb_finish` input 1, `lsb_rob_id` input ROB_W, `lsb_value` input 32 — LSB CDB.

## Operation
- Entry fields: `busy`, `op`, `vj`, `vk`, `qj_busy`, `qk_busy`, `qj`, `qk`, `imm`, `rob_id`, plus `age` when configured.
- **Ready condition:** `busy & !qj_busy & !qk_busy`.

**Dispatch.** When `disp_valid` is high and `rs_full` is low:
- The lowest-index free entry is written.
- Same-cycle wakeup is applied: if `disp_qj_busy` is high and `disp_qj` matches a valid CDB tag this cycle, the entry stores that CDB value and clears its busy flag. The same applies to k. ALU CDB takes priority when both CDBs match.
- `disp_valid` while `rs_full` is high is ignored; the bench flags it as a protocol error.

**Wakeup.** Every busy entry compares `qj`/`qk` against `alu_rob_id` (when `alu_finish`) and `lsb_rob_id` (when `lsb_finish`). On a match it captures the value and clears the pending flag.

**Issue.** Each cycle, one ready entry is selected (see Configuration):
- Its fields are registered onto the `alu_*` outputs with `alu_waiting`=1.
- The entry's `busy` is cleared at the same edge.
- With no ready entry, `alu_waiting`=0 and the other `alu_*` outputs hold their last values.

**Tag pipe.** The issued `rob_id` goes to `issue_tag` at the issue edge. It moves to `alu_rob_id` on the next edge, aligned with ALU `finish`.

**Flush (`RoB_clear`=1 with `rdy_in`).** At the next edge:
- All `busy` flags are cleared.
- `alu_waiting`=0.
- `alu_rob_id` and `issue_tag` return to 0.
- Dispatch in the flush cycle is discarded.

**Stall.** With `rdy_in`=0, no state changes occur: no dispatch, no wakeup, no issue.

## Timing
- **Reset (asynchronous, `rst_in`=0):**
  - All entries free, so `rs_full`=0.
  - `alu_vj`/`alu_vk`/`alu_imm`=0, `alu_op`=0, `alu_waiting`=0.
  - `alu_rob_id`=0, `issue_tag`=0.
  - Reset release mid-operation resumes from the empty state.
- **Latency, dispatch to issue:** an op dispatched ready at edge t can be selected in cycle t+1. It appears on `alu_*` after edge t+1, its ALU result after edge t+2, and `alu_rob_id` after edge t+2.
- **Back-to-back:** one issue per cycle sustained.
- **Dependent chain:** a result on the ALU CDB wakes a consumer that can issue at the next edge.
- **Simultaneous dispatch and issue:** both allowed in one cycle. A slot freed by issue is not reusable until the next cycle, because `rs_full` reflects start-of-cycle state.
- **Wakeup and issue in the same cycle:** an entry woken this cycle is not ready until the next cycle. Selection uses registered flags.

## Configuration
- **`RS_OLDEST_FIRST_EN` defined:**
  - Each entry holds an `age` field of clog2(RS_SIZE) bits.
  - A new entry gets `age`=0. On every accepted dispatch, all other busy entries increment `age`.
  - Issue picks the ready entry with the largest `age`; ties go to the lowest index.
- **Not defined:** `age` storage is removed and issue picks the lowest-index ready entry.

## Test plan
- **Reset:** reset low for 3 cycles, then release -> all outputs 0 and `rs_full`=0. Then dispatch add, vj=5, vk=7, rob 3, both ready -> `alu_waiting`=1 with `alu_op`=add one cycle later; `alu_finish`=1, `alu_value`=12, `alu_rob_id`=3 one cycle after that.
- **Wakeup:** dispatch an op with qj_busy, qj=2; 4 cycles later `lsb_finish` with tag 2, value 0x10 -> issue on the next edge with `alu_vj`=0x10.
- **Fill:** 8 dispatches with operands pending -> `rs_full`=1 after the 8th. A 9th dispatch is ignored. Broadcast tag 1 -> exactly one entry issues, then `rs_full`=0.
- **Flush:** `RoB_clear` asserted with 5 busy entries -> next cycle `rs_full`=0, `alu_waiting`=0. Later broadcasts of those tags produce no issue.
- **Order:** with `RS_OLDEST_FIRST_EN`, entries at index 3 (older) and index 0 both become ready together -> index 3 issues first. Without the macro -> index 0 issues first.
- **Same-cycle hazards:** dispatch with qj=4 in the same cycle `alu_finish` carries tag 4 and value 9 -> entry captured ready with vj=9. Hold `rdy_in`=0 for 2 cycles mid-stream -> outputs frozen, no lost entries.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops, snoops both CDBs for operands, issues one ready op per cycle.
// Define RS_OLDEST_FIRST_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_alu #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             RoB_clear,
   input  logic             disp_valid,
   input  logic [5:0]       disp_op,
   input  logic [31:0]      disp_vj,
   input  logic [31:0]      disp_vk,
   input  logic             disp_qj_busy,
   input  logic             disp_qk_busy,
   input  logic [ROB_W-1:0] disp_qj,
   input  logic [ROB_W-1:0] disp_qk,
   input  logic [31:0]      disp_imm,
   input  logic [ROB_W-1:0] disp_rob_id,
   output logic             rs_full,
   output logic [31:0]      alu_vj,
   output logic [31:0]      alu_vk,
   output logic [31:0]      alu_imm,
   output logic [5:0]       alu_op,
   output logic             alu_waiting,
   input  logic             alu_finish,
   input  logic [31:0]      alu_value,
   output logic [ROB_W-1:0] alu_rob_id,
   input  logic             lsb_finish,
   input  logic [ROB_W-1:0] lsb_rob_id,
   input  logic [31:0]      lsb_value
);
   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] ent_busy, ent_qjb, ent_qkb, ready;
   logic [5:0]         ent_op  [RS_SIZE];
   logic [31:0]        ent_vj  [RS_SIZE];
   logic [31:0]        ent_vk  [RS_SIZE];
   logic [31:0]        ent_imm [RS_SIZE];
   logic [ROB_W-1:0]   ent_qj  [RS_SIZE];
   logic [ROB_W-1:0]   ent_qk  [RS_SIZE];
   logic [ROB_W-1:0]   ent_rob [RS_SIZE];
   logic [ROB_W-1:0]   issue_tag;

   logic [RS_SIZE-1:0] wj_hit, wk_hit;
   logic [31:0]        wj_val [RS_SIZE];
   logic [31:0]        wk_val [RS_SIZE];
   logic               dj_hit, dk_hit, disp_acc, sel_vld;
   logic [31:0]        dj_val, dk_val;
   logic [IDX_W-1:0]   sel_idx, free_idx;

   // ALU CDB wins when both buses carry the wanted tag
   function automatic logic [32:0] cdb_snoop(input logic pend, input logic [ROB_W-1:0] q);
      if (pend && alu_finish && q == alu_rob_id) return {1'b1, alu_value};
      if (pend && lsb_finish && q == lsb_rob_id) return {1'b1, lsb_value};
      return {1'b0, 32'd0};
   endfunction

`ifdef RS_OLDEST_FIRST_EN
   logic [IDX_W-1:0] ent_age [RS_SIZE];
   logic [IDX_W-1:0] sel_age;

   function automatic logic [IDX_W-1:0] age_inc(input logic [IDX_W-1:0] a);
      return (&a) ? a : a + 1'b1;
   endfunction
`endif

   assign rs_full  = &ent_busy;
   assign ready    = ent_busy & ~ent_qjb & ~ent_qkb;
   assign disp_acc = disp_valid && !rs_full;

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         {wj_hit[i], wj_val[i]} = cdb_snoop(ent_busy[i] & ent_qjb[i], ent_qj[i]);
         {wk_hit[i], wk_val[i]} = cdb_snoop(ent_busy[i] & ent_qkb[i], ent_qk[i]);
      end
      {dj_hit, dj_val} = cdb_snoop(disp_qj_busy, disp_qj);
      {dk_hit, dk_val} = cdb_snoop(disp_qk_busy, disp_qk);
   end

   always_comb begin
      free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (!ent_busy[i]) free_idx = IDX_W'(i);
   end

   // Selection sees only start-of-cycle flags, so same-cycle wakeups wait a cycle
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
      sel_age = '0;
      for (int i = 0; i < RS_SIZE; i++)
         if (ready[i] && (!sel_vld || ent_age[i] > sel_age)) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(i);
            sel_age = ent_age[i];
         end
`else
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (ready[i]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(i);
         end
`endif
   end

   // Control state and issue registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ent_busy    <= '0;
         ent_qjb     <= '0;
         ent_qkb     <= '0;
         alu_waiting <= 1'b0;
         alu_op      <= '0;
         alu_vj      <= '0;
         alu_vk      <= '0;
         alu_imm     <= '0;
         issue_tag   <= '0;
         alu_rob_id  <= '0;
      end else if (rdy_in) begin
         if (RoB_clear) begin
            ent_busy    <= '0;
            alu_waiting <= 1'b0;
            issue_tag   <= '0;
            alu_rob_id  <= '0;
         end else begin
            alu_rob_id  <= issue_tag;
            alu_waiting <= sel_vld;
            if (sel_vld) begin
               issue_tag         <= ent_rob[sel_idx];
               alu_op            <= ent_op[sel_idx];
               alu_vj            <= ent_vj[sel_idx];
               alu_vk            <= ent_vk[sel_idx];
               alu_imm           <= ent_imm[sel_idx];
               ent_busy[sel_idx] <= 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
               if (wj_hit[i]) ent_qjb[i] <= 1'b0;
               if (wk_hit[i]) ent_qkb[i] <= 1'b0;
            end
            if (disp_acc) begin
               ent_busy[free_idx] <= 1'b1;
               ent_qjb[free_idx]  <= disp_qj_busy & ~dj_hit;
               ent_qkb[free_idx]  <= disp_qk_busy & ~dk_hit;
            end
         end
      end
   end

   // Entry payload: meaningful only while busy, so no reset
   always_ff @(posedge clk_in) begin
      if (rdy_in && !RoB_clear) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (wj_hit[i]) ent_vj[i] <= wj_val[i];
            if (wk_hit[i]) ent_vk[i] <= wk_val[i];
         end
         if (disp_acc) begin
            ent_op[free_idx]  <= disp_op;
            ent_vj[free_idx]  <= dj_hit ? dj_val : disp_vj;
            ent_vk[free_idx]  <= dk_hit ? dk_val : disp_vk;
            ent_qj[free_idx]  <= disp_qj;
            ent_qk[free_idx]  <= disp_qk;
            ent_imm[free_idx] <= disp_imm;
            ent_rob[free_idx] <= disp_rob_id;
         end
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   always_ff @(posedge clk_in) begin
      if (rdy_in && !RoB_clear && disp_acc)
         for (int i = 0; i < RS_SIZE; i++) begin
            if (IDX_W'(i) == free_idx) ent_age[i] <= '0;
            else if (ent_busy[i])      ent_age[i] <= age_inc(ent_age[i]);
         end
   end
`endif

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus random traffic, all checked against an entry-table model.
module tb_rs_alu;
   localparam int RS_SIZE = 8;
   localparam int ROB_W   = 4;
   localparam logic [5:0] OP_ADD = 6'h01;

   logic             clk_in = 1'b0;
   logic             rst_in, rdy_in, RoB_clear, disp_valid;
   logic [5:0]       disp_op;
   logic [31:0]      disp_vj, disp_vk, disp_imm;
   logic             disp_qj_busy, disp_qk_busy;
   logic [ROB_W-1:0] disp_qj, disp_qk, disp_rob_id;
   logic             rs_full;
   logic [31:0]      alu_vj, alu_vk, alu_imm;
   logic [5:0]       alu_op;
   logic             alu_waiting;
   logic             alu_finish;
   logic [31:0]      alu_value;
   logic [ROB_W-1:0] alu_rob_id;
   logic             lsb_finish;
   logic [ROB_W-1:0] lsb_rob_id;
   logic [31:0]      lsb_value;

   always #5 clk_in = ~clk_in;

   rs_alu #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy), .disp_qj(disp_qj),
      .disp_qk(disp_qk), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id), .rs_full(rs_full),
      .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_op(alu_op),
      .alu_waiting(alu_waiting), .alu_finish(alu_finish), .alu_value(alu_value),
      .alu_rob_id(alu_rob_id), .lsb_finish(lsb_finish), .lsb_rob_id(lsb_rob_id),
      .lsb_value(lsb_value)
   );

   typedef struct {
      bit               busy;
      bit               jb;
      bit               kb;
      logic [ROB_W-1:0] qj;
      logic [ROB_W-1:0] qk;
      logic [ROB_W-1:0] rob;
      logic [31:0]      vj;
      logic [31:0]      vk;
      logic [31:0]      imm;
      logic [5:0]       op;
      int               seq;
   } ent_t;

   ent_t             m [RS_SIZE];
   int               disp_cnt;
   logic [31:0]      e_vj, e_vk, e_imm;
   logic [5:0]       e_op;
   logic             e_wait;
   logic [ROB_W-1:0] e_tag, e_rob;
   int               n_checks = 0;
   int               n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_full();
      for (int i = 0; i < RS_SIZE; i++)
         if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      e_vj = '0; e_vk = '0; e_imm = '0; e_op = '0;
      e_wait = 1'b0; e_tag = '0; e_rob = '0;
   endtask

   // One clock: advance the model on the inputs in force, take the edge, play the ALU, compare.
   task automatic cycle();
      int sel, fr, age, best;
      bit full;
      logic p_wait;
      logic [31:0] p_vj, p_vk, p_imm;
      logic [ROB_W-1:0] cdb;
      p_wait = alu_waiting; p_vj = alu_vj; p_vk = alu_vk; p_imm = alu_imm;
      if (rst_in && rdy_in && disp_valid && rs_full)
         $display("protocol: dispatch while rs_full, the RS must ignore it (t=%0t)", $time);
      if (!rst_in) model_reset();
      else if (rdy_in) begin
         if (RoB_clear) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            e_wait = 1'b0; e_tag = '0; e_rob = '0;
         end else begin
            full = model_full();
            fr = -1;
            for (int i = RS_SIZE - 1; i >= 0; i--) if (!m[i].busy) fr = i;
            sel = -1; best = -1;
            for (int i = 0; i < RS_SIZE; i++)
               if (m[i].busy && !m[i].jb && !m[i].kb) begin
`ifdef RS_OLDEST_FIRST_EN
                  age = disp_cnt - m[i].seq;
                  if (age > RS_SIZE - 1) age = RS_SIZE - 1;
`else
                  age = 0;
`endif
                  if (age > best) begin best = age; sel = i; end
               end
            cdb = e_rob;
            for (int i = 0; i < RS_SIZE; i++) begin
               if (m[i].busy && m[i].jb) begin
                  if (alu_finish && m[i].qj == cdb) begin m[i].jb = 0; m[i].vj = alu_value; end
                  else if (lsb_finish && m[i].qj == lsb_rob_id) begin m[i].jb = 0; m[i].vj = lsb_value; end
               end
               if (m[i].busy && m[i].kb) begin
                  if (alu_finish && m[i].qk == cdb) begin m[i].kb = 0; m[i].vk = alu_value; end
                  else if (lsb_finish && m[i].qk == lsb_rob_id) begin m[i].kb = 0; m[i].vk = lsb_value; end
               end
            end
            e_rob = e_tag;
            e_wait = (sel >= 0);
            if (sel >= 0) begin
               e_tag = m[sel].rob; e_op = m[sel].op; e_vj = m[sel].vj;
               e_vk = m[sel].vk; e_imm = m[sel].imm; m[sel].busy = 1'b0;
            end
            if (disp_valid && !full) begin
               m[fr].busy = 1'b1; m[fr].op = disp_op; m[fr].imm = disp_imm; m[fr].rob = disp_rob_id;
               m[fr].qj = disp_qj; m[fr].qk = disp_qk;
               m[fr].jb = disp_qj_busy; m[fr].vj = disp_vj;
               m[fr].kb = disp_qk_busy; m[fr].vk = disp_vk;
               if (disp_qj_busy && alu_finish && disp_qj == cdb) begin m[fr].jb = 0; m[fr].vj = alu_value; end
               else if (disp_qj_busy && lsb_finish && disp_qj == lsb_rob_id) begin m[fr].jb = 0; m[fr].vj = lsb_value; end
               if (disp_qk_busy && alu_finish && disp_qk == cdb) begin m[fr].kb = 0; m[fr].vk = alu_value; end
               else if (disp_qk_busy && lsb_finish && disp_qk == lsb_rob_id) begin m[fr].kb = 0; m[fr].vk = lsb_value; end
               disp_cnt++;
               m[fr].seq = disp_cnt;
            end
         end
      end
      @(posedge clk_in);
      #1;
      if (!rst_in) alu_finish = 1'b0;
      else if (rdy_in) begin
         alu_finish = RoB_clear ? 1'b0 : p_wait;
         alu_value  = p_vj + p_vk + p_imm;
      end
      disp_valid = 1'b0; lsb_finish = 1'b0; RoB_clear = 1'b0;
      chk("rs_full", 32'(rs_full), 32'(model_full()));
      chk("alu_waiting", 32'(alu_waiting), 32'(e_wait));
      chk("alu_op", 32'(alu_op), 32'(e_op));
      chk("alu_vj", alu_vj, e_vj);
      chk("alu_vk", alu_vk, e_vk);
      chk("alu_imm", alu_imm, e_imm);
      chk("alu_rob_id", 32'(alu_rob_id), 32'(e_rob));
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic jb, input logic [ROB_W-1:0] qj, input logic kb,
                       input logic [ROB_W-1:0] qk, input logic [31:0] imm, input logic [ROB_W-1:0] rob);
      disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
      disp_qj_busy = jb; disp_qj = qj; disp_qk_busy = kb; disp_qk = qk;
      disp_imm = imm; disp_rob_id = rob;
   endtask

   task automatic lsb(input logic [ROB_W-1:0] tag, input logic [31:0] val);
      lsb_finish = 1'b1; lsb_rob_id = tag; lsb_value = val;
   endtask

   task automatic rand_inputs();
      rdy_in = ($urandom_range(0, 9) != 0);
      RoB_clear = ($urandom_range(0, 79) == 0);
      if (!model_full() && $urandom_range(0, 9) < 6)
         disp(6'($urandom), $urandom, $urandom, 1'($urandom), ROB_W'($urandom),
              1'($urandom), ROB_W'($urandom), $urandom, ROB_W'($urandom));
      if ($urandom_range(0, 9) < 3) lsb(ROB_W'($urandom), $urandom);
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; RoB_clear = 1'b0; disp_valid = 1'b0;
      disp_op = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0;
      disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0; disp_rob_id = '0;
      alu_finish = 1'b0; alu_value = '0; lsb_finish = 1'b0; lsb_rob_id = '0; lsb_value = '0;
      disp_cnt = 0;
      model_reset();

      // reset, then a single ready add
      repeat (3) cycle();
      rst_in = 1'b1;
      chk("rst_full", 32'(rs_full), 32'd0);
      chk("rst_wait", 32'(alu_waiting), 32'd0);
      chk("rst_rob", 32'(alu_rob_id), 32'd0);
      disp(OP_ADD, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0, 32'd0, 4'd3);
      cycle();
      chk("add_not_yet", 32'(alu_waiting), 32'd0);
      cycle();
      chk("add_wait", 32'(alu_waiting), 32'd1);
      chk("add_op", 32'(alu_op), 32'(OP_ADD));
      cycle();
      chk("add_value", alu_value, 32'd12);
      chk("add_rob", 32'(alu_rob_id), 32'd3);

      // wakeup from the LSB bus
      disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, '0, 32'd0, 4'd5);
      cycle();
      repeat (4) cycle();
      lsb(4'd2, 32'h10);
      cycle();
      chk("wake_same_cycle", 32'(alu_waiting), 32'd0);
      cycle();
      chk("wake_wait", 32'(alu_waiting), 32'd1);
      chk("wake_vj", alu_vj, 32'h10);
      repeat (2) cycle();

      // fill all entries, overflow dispatch, release one
      for (int k = 0; k < RS_SIZE; k++) begin
         disp(OP_ADD, 32'd0, 32'd0, 1'b1, (k == 0) ? 4'd1 : 4'(8 + k), 1'b0, '0, 32'h100 + k, 4'(k));
         cycle();
      end
      chk("fill_full", 32'(rs_full), 32'd1);
      disp(OP_ADD, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0, 32'h999, 4'd15);
      cycle();
      chk("fill_overflow_full", 32'(rs_full), 32'd1);
      lsb(4'd1, 32'd3);
      cycle();
      chk("fill_wake_wait", 32'(alu_waiting), 32'd0);
      cycle();
      chk("fill_issue", 32'(alu_waiting), 32'd1);
      chk("fill_issue_imm", alu_imm, 32'h100);
      chk("fill_not_full", 32'(rs_full), 32'd0);
      cycle();
      chk("fill_one_only", 32'(alu_waiting), 32'd0);
      RoB_clear = 1'b1;
      cycle();

      // flush with five pending entries
      for (int k = 0; k < 5; k++) begin
         disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'(8 + k), 1'b0, '0, 32'h200 + k, 4'(8 + k));
         cycle();
      end
      RoB_clear = 1'b1;
      cycle();
      chk("flush_full", 32'(rs_full), 32'd0);
      chk("flush_wait", 32'(alu_waiting), 32'd0);
      chk("flush_rob", 32'(alu_rob_id), 32'd0);
      for (int k = 0; k < 6; k++) begin
         if (k < 5) lsb(4'(8 + k), 32'd1);
         cycle();
         chk("flush_no_issue", 32'(alu_waiting), 32'd0);
      end

      // issue order: entry 3 is older than entry 0
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, '0, 32'hA0, 4'd7);  cycle();
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, '0, 32'hB0, 4'd8); cycle();
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, '0, 32'hC0, 4'd9); cycle();
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, '0, 32'h33, 4'd3);  cycle();
      lsb(4'd2, 32'd1);
      cycle();
      cycle();
      chk("order_a_issue", alu_imm, 32'hA0);
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, '0, 32'h00, 4'd0);
      cycle();
      lsb(4'd6, 32'd2);
      cycle();
      cycle();
`ifdef RS_OLDEST_FIRST_EN
      chk("order_first", alu_imm, 32'h33);
`else
      chk("order_first", alu_imm, 32'h00);
`endif
      cycle();
      chk("order_second_wait", 32'(alu_waiting), 32'd1);
      RoB_clear = 1'b1;
      cycle();

      // dispatch while the ALU CDB carries the wanted tag
      disp(OP_ADD, 32'd4, 32'd5, 1'b0, '0, 1'b0, '0, 32'd0, 4'd4);
      cycle();
      cycle();
      cycle();
      chk("same_rob", 32'(alu_rob_id), 32'd4);
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd4, 1'b0, '0, 32'h77, 4'd6);
      cycle();
      chk("same_hold", 32'(alu_waiting), 32'd0);
      cycle();
      chk("same_wait", 32'(alu_waiting), 32'd1);
      chk("same_vj", alu_vj, 32'd9);

      // stall for two cycles mid-stream
      disp(OP_ADD, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0, 32'h51, 4'd1); cycle();
      disp(OP_ADD, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0, 32'h52, 4'd2); cycle();
      chk("stall_pre_imm", alu_imm, 32'h51);
      rdy_in = 1'b0;
      repeat (2) cycle();
      chk("stall_wait", 32'(alu_waiting), 32'd1);
      chk("stall_imm", alu_imm, 32'h51);
      rdy_in = 1'b1;
      cycle();
      chk("stall_resume_imm", alu_imm, 32'h52);
      cycle();
      chk("stall_drained", 32'(alu_waiting), 32'd0);

      // random traffic with an asynchronous reset partway through
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            rst_in = 1'b0;
            model_reset();
            alu_finish = 1'b0;
            #1;
            chk("async_rst_full", 32'(rs_full), 32'd0);
            chk("async_rst_wait", 32'(alu_waiting), 32'd0);
            chk("async_rst_vj", alu_vj, 32'd0);
            chk("async_rst_rob", 32'(alu_rob_id), 32'd0);
            rdy_in = 1'b1;
            repeat (2) cycle();
            rst_in = 1'b1;
         end
         rand_inputs();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
